// File: rtl/dmem_if.sv
// Core-side data memory bus between the load/store stage and the responder.
interface dmem_if;
    logic [31:0] mem_addr_mem;
    logic [31:0] mem_wdata_mem;
    logic        mem_write_mem;
    logic        mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic [31:0] mem_rdata_mem;
    logic        stall_pipl;
    logic        access_err;

    // Pipeline side: issues requests, receives data/stall/error
    modport master (
        output mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
        input  mem_rdata_mem, stall_pipl, access_err
    );

    // Memory side: accepts requests, returns data/stall/error
    modport slave (
        input  mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
        output mem_rdata_mem, stall_pipl, access_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data memory responder: byte/half/word loads and stores with
// alignment, range and legality checking, and a pipeline stall output.
module dmem_responder #(
    parameter int unsigned DMEM_DEPTH  = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);
    localparam int unsigned AW       = $clog2(DMEM_DEPTH);
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_latch;
    logic        w_stall;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_op;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DMEM_DEPTH];

    logic        w_req;
    logic        w_in_idle;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_op;
    logic        w_rd;
    logic        w_wr;
    logic [29:0] w_word;
    logic [AW-1:0] w_idx;
    logic        w_oor;
    logic        w_misal;
    logic        w_illegal;
    logic        w_err;
    logic        w_enter_resp;
    logic        w_commit;
    logic [3:0]  w_be;
    logic [31:0] w_wr_word;
    logic [31:0] w_rd_word;
    logic [31:0] w_shift;
    logic [31:0] w_ld_data;

    assign w_req = bus.mem_read_mem | bus.mem_write_mem;

    // State and wait counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter, request capture and stall
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    w_stall = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) w_state_nxt = S_RESP;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the request so it stays stable through the wait states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_op    <= 3'b000;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else if (w_latch) begin
            r_addr  <= bus.mem_addr_mem;
            r_wdata <= bus.mem_wdata_mem;
            r_op    <= bus.mem_op_mem;
            r_rd    <= bus.mem_read_mem;
            r_wr    <= bus.mem_write_mem;
        end
    end

    // Access in flight: live inputs in IDLE (zero-wait case), captured copy otherwise
    always_comb begin
        w_in_idle = (r_state == S_IDLE);
        w_addr    = w_in_idle ? bus.mem_addr_mem  : r_addr;
        w_wdata   = w_in_idle ? bus.mem_wdata_mem : r_wdata;
        w_op      = w_in_idle ? bus.mem_op_mem    : r_op;
        w_rd      = w_in_idle ? bus.mem_read_mem  : r_rd;
        w_wr      = w_in_idle ? bus.mem_write_mem : r_wr;
    end

    // Address decode and error classification
    always_comb begin
        w_word    = 30'((w_addr - BASE_ADDR) >> 2);
        w_idx     = w_word[AW-1:0];
        w_oor     = (w_word >= 30'(DMEM_DEPTH));
        w_misal   = ((w_op[1:0] == 2'b01) && w_addr[0]) ||
                    ((w_op[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
        w_illegal = (w_rd && w_wr) || (w_op == 3'b011) || (w_op == 3'b110) || (w_op == 3'b111);
        w_err     = w_oor || w_misal || w_illegal;
    end

    assign w_enter_resp = (w_state_nxt == S_RESP);
    assign w_commit     = w_enter_resp && w_wr && !w_err && !reset;

    // Store lane enables and lane-replicated store data
    always_comb begin
        w_be      = 4'b0000;
        w_wr_word = 32'h0;
        case (w_op[1:0])
            2'b00: begin
                w_be      = 4'b0001 << w_addr[1:0];
                w_wr_word = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be      = 4'b0011 << w_addr[1:0];
                w_wr_word = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_wr_word = w_wdata;
            end
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        w_rd_word = r_mem[w_idx];
        w_shift   = w_rd_word >> {w_addr[1:0], 3'b000};
        case (w_op)
            3'b000:  w_ld_data = {{24{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ld_data = {24'h0, w_shift[7:0]};
            3'b101:  w_ld_data = {16'h0, w_shift[15:0]};
            default: w_ld_data = w_shift;
        endcase
    end

    // Byte-lane store commit on the edge entering RESP; array is never reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
            end
        end
    end

    // Response registers: load data held between loads, one-cycle error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_enter_resp && w_err;
            if (w_enter_resp && w_rd) r_rdata <= w_err ? 32'h0 : w_ld_data;
        end
    end

    assign bus.mem_rdata_mem = r_rdata;
    assign bus.stall_pipl    = w_stall;
    assign bus.access_err    = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance at base 0 and a
// zero-wait instance at base 0x8000_0000 with a 64-word array.
module tb_dmem_responder;
    localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                           OP_BU = 3'b100, OP_HU = 3'b101;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_if bus_ws2 ();
    dmem_if bus_ws0 ();

    dmem_responder #(.DMEM_DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000))
        u_ws2 (.clk(clk), .reset(reset), .bus(bus_ws2));
    dmem_responder #(.DMEM_DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(32'h8000_0000))
        u_ws0 (.clk(clk), .reset(reset), .bus(bus_ws0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;       // 0: 2-wait instance, 1: zero-wait instance
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit sel, input logic rd, input logic wr,
                                input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input bit chk_data, input logic exp_err);
        vec_t v;
        v.sel = sel; v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.chk_data = chk_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            bus_ws0.mem_read_mem = rd; bus_ws0.mem_write_mem = wr; bus_ws0.mem_op_mem = op;
            bus_ws0.mem_addr_mem = addr; bus_ws0.mem_wdata_mem = wdata;
        end else begin
            bus_ws2.mem_read_mem = rd; bus_ws2.mem_write_mem = wr; bus_ws2.mem_op_mem = op;
            bus_ws2.mem_addr_mem = addr; bus_ws2.mem_wdata_mem = wdata;
        end
    endtask

    function automatic logic get_stall(input bit sel);
        return sel ? bus_ws0.stall_pipl : bus_ws2.stall_pipl;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? bus_ws0.access_err : bus_ws2.access_err;
    endfunction
    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus_ws0.mem_rdata_mem : bus_ws2.mem_rdata_mem;
    endfunction

    // One complete access: count stall cycles, sample RESP outputs, then one idle cycle
    task automatic access(input bit sel, input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output logic err_after, output int n);
        @(negedge clk);
        drive(sel, rd, wr, op, addr, wdata);
        #1;
        n = 0;
        while (get_stall(sel) && n < 40) begin
            n++;
            @(negedge clk);
        end
        rdata = get_rdata(sel);
        err   = get_err(sel);
        drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        err_after = get_err(sel);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        logic        err, err_after;
        int          n;
        logic [7:0]  pat;
        logic [31:0] rd3, rd7;

        // 2-wait instance, base 0
        vecs.push_back(mk(0, 0, 1, OP_W,  32'h10,   32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h10,   32'h0,        32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_B,  32'h11,   32'h12345680, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, OP_B,  32'h11,   32'h0,        32'hFFFFFF80, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_BU, 32'h11,   32'h0,        32'h00000080, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h10,   32'h0,        32'hDEAD80EF, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_H,  32'h13,   32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h10,   32'h0,        32'hDEAD80EF, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_H,  32'h12,   32'h1111CAFE, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h10,   32'h0,        32'hCAFE80EF, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_H,  32'h12,   32'h0,        32'hFFFFCAFE, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_HU, 32'h12,   32'h0,        32'h0000CAFE, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_W,  32'h0,    32'hA5A5A5A5, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 1, OP_W,  32'h1000, 32'h55555555, 32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h0,    32'h0,        32'hA5A5A5A5, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h1000, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 3'b011, 32'h10,  32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 1, 3'b110, 32'h10,  32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h10,   32'h0,        32'hCAFE80EF, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_W,  32'h14,   32'h01020304, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 1, OP_W,  32'h15,   32'hFFFFFFFF, 32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h14,   32'h0,        32'h01020304, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_B,  32'h17,   32'h000000AB, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h14,   32'h0,        32'hAB020304, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_W,  32'h18,   32'h0,        32'hAB020304, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_B,  32'h17,   32'h0,        32'hFFFFFFAB, 1, 0));
        vecs.push_back(mk(0, 1, 0, OP_HU, 32'h16,   32'h0,        32'h0000AB02, 1, 0));
        vecs.push_back(mk(0, 0, 1, OP_H,  32'h15,   32'h0000FFFF, 32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 0, OP_W,  32'h14,   32'h0,        32'hAB020304, 1, 0));
        // Zero-wait instance, base 0x8000_0000, 64 words
        vecs.push_back(mk(1, 0, 1, OP_W,  32'h80000020, 32'h11223344, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 1, OP_W,  32'h80000020, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(1, 1, 0, OP_W,  32'h80000020, 32'h0,        32'h11223344, 1, 0));
        vecs.push_back(mk(1, 1, 0, OP_BU, 32'h80000023, 32'h0,        32'h00000011, 1, 0));
        vecs.push_back(mk(1, 1, 0, OP_H,  32'h80000022, 32'h0,        32'h00001122, 1, 0));
        vecs.push_back(mk(1, 1, 0, OP_W,  32'h80000100, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(1, 1, 0, OP_W,  32'h00000020, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(1, 0, 1, OP_W,  32'h800000FC, 32'h77777777, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 0, OP_W,  32'h800000FC, 32'h0,        32'h77777777, 1, 0));

        // Reset state
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset%0d stall", s), 32'(get_stall(s[0])), 32'h0);
            check($sformatf("reset%0d err", s),   32'(get_err(s[0])),   32'h0);
            check($sformatf("reset%0d rdata", s), get_rdata(s[0]),      32'h0);
        end
        reset = 1'b0;

        // Idle with no request: no stall
        repeat (2) @(negedge clk);
        check("idle stall", 32'(get_stall(0)), 32'h0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].op, vecs[i].addr,
                   vecs[i].wdata, rdata, err, err_after, n);
            check($sformatf("v%0d stall_cycles", i), 32'(n), vecs[i].sel ? 32'd1 : 32'd3);
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d err_pulse_end", i), 32'(err_after), 32'h0);
            if (vecs[i].chk_data) check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Back-to-back: LW held high for 8 cycles -> two full accesses, no extra
        @(negedge clk);
        drive(0, 1'b1, 1'b0, OP_W, 32'h10, 32'h0);
        #1;
        pat = 8'h0;
        rd3 = 32'h0;
        rd7 = 32'h0;
        for (int c = 0; c < 8; c++) begin
            pat[c] = get_stall(0);
            if (c == 3) rd3 = get_rdata(0);
            if (c == 7) rd7 = get_rdata(0);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("b2b stall pattern", 32'(pat), 32'h77);
        check("b2b rdata first", rd3, 32'hCAFE80EF);
        check("b2b rdata second", rd7, 32'hCAFE80EF);
        @(negedge clk);
        check("b2b idle after", 32'(get_stall(0)), 32'h0);

        // Reset in second WAIT cycle aborts the pending store
        access(0, 1'b0, 1'b1, OP_W, 32'h24, 32'h0BADF00D, rdata, err, err_after, n);
        check("pre-store err", 32'(err), 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, OP_W, 32'h24, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        check("abort in wait2 stall", 32'(get_stall(0)), 32'h1);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("abort stall", 32'(get_stall(0)), 32'h0);
        check("abort err",   32'(get_err(0)),   32'h0);
        check("abort rdata", get_rdata(0),      32'h0);
        reset = 1'b0;
        access(0, 1'b1, 1'b0, OP_W, 32'h24, 32'h0, rdata, err, err_after, n);
        check("abort old value", rdata, 32'h0BADF00D);
        check("abort reread stall", 32'(n), 32'd3);
        access(0, 1'b1, 1'b0, OP_W, 32'h10, 32'h0, rdata, err, err_after, n);
        check("array kept over reset", rdata, 32'hCAFE80EF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
